uart_tx: RTL

Single-clock UART transmitter: accepts one data word per valid/ready handshake and serialises it onto `tx_line` as 1 start bit, DATA_COUNT data bits (LSB first) and STOP_COUNT stop bits. Bit timing matches the design's UART receiver for the same CLK_DIV_COUNT, so the two loop back directly. It sits between the host-side response logic and the board's TX pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_baud_tick.sv | 19 +
 rtl/uart_tx.sv | 98 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and bit-timing helper for the UART blocks.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} tx_state_t;
  function automatic int bit_period(input int clk_div);
    return 2 * clk_div;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with synchronous restart and a one-cycle bit_end strobe.
module uart_baud_tick #(
  parameter int CLK_DIV_COUNT = 30,
  parameter int CLK_DIV_WIDTH = 5
) (
  input  logic clk_in,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);
  import uart_pkg::*;
  localparam int CW = CLK_DIV_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(bit_period(CLK_DIV_COUNT) - 1);
  logic [CW-1:0] cnt;
  assign bit_end = cnt == LAST;
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (restart || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready UART transmitter, 1 start, DATA_COUNT data (LSB first), STOP_COUNT stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input and BREAK state.
module uart_tx #(
  parameter int CLK_DIV_COUNT = 30,
  parameter int CLK_DIV_WIDTH = 5,
  parameter int DATA_COUNT    = 8,
  parameter int STOP_COUNT    = 1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_COUNT-1:0] tx_data,
  input  logic                  tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                  tx_break,
`endif
  output logic                  tx_ready,
  output logic                  tx_line,
  output logic                  tx_running
);
  import uart_pkg::*;
  localparam int BW = $clog2(DATA_COUNT + STOP_COUNT + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_COUNT - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_COUNT - 1);
  tx_state_t state, state_nxt;
  logic [DATA_COUNT-1:0] shift, shift_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic restart, bit_end, line_nxt;
  uart_baud_tick #(
    .CLK_DIV_COUNT(CLK_DIV_COUNT),
    .CLK_DIV_WIDTH(CLK_DIV_WIDTH)
  ) u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .restart(restart),
    .bit_end(bit_end)
  );
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    restart     = 1'b0;
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (tx_break) state_nxt = BREAK;
        else
`endif
        if (tx_valid) begin
          state_nxt   = START;
          shift_nxt   = tx_data;
          bit_cnt_nxt = '0;
          restart     = 1'b1;
        end
      end
      START: state_nxt = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_nxt   = shift >> 1;
        bit_cnt_nxt = (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
        state_nxt   = (bit_cnt == LAST_DATA) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        bit_cnt_nxt = (bit_cnt == LAST_STOP) ? '0 : bit_cnt + 1'b1;
        state_nxt   = (bit_cnt == LAST_STOP) ? IDLE : STOP;
      end
      BREAK: begin
`ifdef UART_TX_BREAK_EN
        // stop bits are timed from the release of tx_break, so restart the divider
        if (!tx_break) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
          restart     = 1'b1;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    line_nxt = (state_nxt == START || state_nxt == BREAK) ? 1'b0 :
               (state_nxt == DATA) ? shift_nxt[0] : 1'b1;
  end
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      tx_line    <= 1'b1;
      tx_ready   <= 1'b1;
      tx_running <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      tx_line    <= line_nxt;
      tx_ready   <= state_nxt == IDLE;
      tx_running <= state_nxt != IDLE;
    end
endmodule
